// File: rtl/mic_spi_capture_fifo.sv
// Self-timed microphone ADC capture: a sample-rate tick starts a 16-bit SPI read whose result is pushed into a show-ahead sample FIFO.
// Optional build macro MIC_FIFO_DROP_OLDEST_EN: a push on full overwrites the oldest entry instead of discarding the new sample.
module mic_spi_capture_fifo #(
  parameter int unsigned SAMPLE_DIV = 500,
  parameter int unsigned SCLK_DIV   = 2,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     fixed_clock,
  input  logic                     PRESETn,
  input  logic                     enable,
  input  logic                     MISO,
  output logic                     CS_b,
  output logic                     sclk,
  input  logic                     rd_en,
  output logic [15:0]              rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     sample_pulse,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned DIV_W  = $clog2(SCLK_DIV + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic              half_q, half_d;
  logic [15:0]       shreg_q, shreg_d;
  logic              cs_b_q, cs_b_d;
  logic              sclk_q, sclk_d;
  logic              pulse_q, pulse_d;
  logic              tick_c, div_last_c;

  logic [15:0]       mem_q [DEPTH];
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  fill_q, fill_d, fill_c;
  logic [PTR_W-1:0]  wr_ptr_c, rd_ptr_d;
  logic [15:0]       rd_data_q, head_d;
  logic              rd_valid_q;
  logic              ovf_q, ovf_d;
  logic              push_c, pop_c, full_c, wr_en_c, ovf_set_c;

  assign tick_c     = (cnt_q == TICK_W'(SAMPLE_DIV - 1));
  assign div_last_c = (div_q == DIV_W'(SCLK_DIV - 1));

  // State registers for tick counter and SPI frame sequencer
  always_ff @(posedge fixed_clock or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      shreg_q <= '0;
      cs_b_q  <= 1'b1;
      sclk_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      shreg_q <= shreg_d;
      cs_b_q  <= cs_b_d;
      sclk_q  <= sclk_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state: tick counter, frame phases, and registered pin values derived from the next state
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    half_d  = half_q;
    shreg_d = shreg_q;
    if (!enable || tick_c) cnt_d = '0;
    else                   cnt_d = cnt_q + TICK_W'(1);

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (tick_c) state_d = SETUP;
      end
      SETUP: begin
        if (div_last_c) begin
          div_d   = '0;
          bit_d   = '0;
          half_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_last_c) begin
          div_d = '0;
          if (!half_q) begin
            // sclk rises on this edge: capture MISO
            half_d  = 1'b1;
            shreg_d = {shreg_q[14:0], MISO};
          end else if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            half_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_last_c) begin
          div_d   = '0;
          state_d = PUSH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_b_d  = !((state_d == SETUP) || (state_d == SHIFT));
    sclk_d  = !((state_d == SHIFT) && !half_d);
    pulse_d = (state_d == PUSH);
  end

  assign push_c   = (state_q == PUSH);
  assign fill_c   = wr_cnt_q - rd_cnt_q;
  assign full_c   = (fill_c == CNT_W'(DEPTH));
  assign pop_c    = rd_en && (fill_c != '0);
  assign wr_ptr_c = wr_cnt_q[PTR_W-1:0];

  // FIFO pointer update; head_d looks ahead so rd_data stays registered
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_en_c   = 1'b0;
    ovf_set_c = 1'b0;
    if (pop_c) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (push_c) begin
      if (!full_c || pop_c) begin
        wr_en_c  = 1'b1;
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else begin
        ovf_set_c = 1'b1;
`ifdef MIC_FIFO_DROP_OLDEST_EN
        wr_en_c  = 1'b1;
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
`endif
      end
    end
    fill_d   = wr_cnt_d - rd_cnt_d;
    rd_ptr_d = rd_cnt_d[PTR_W-1:0];
    head_d   = (wr_en_c && (wr_ptr_c == rd_ptr_d)) ? shreg_q : mem_q[rd_ptr_d];
    ovf_d    = ovf_set_c | (ovf_q & ~overflow_clr);
  end

  always_ff @(posedge fixed_clock) begin
    if (wr_en_c) mem_q[wr_ptr_c] <= shreg_q;
  end

  always_ff @(posedge fixed_clock or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      fill_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      fill_q     <= fill_d;
      rd_data_q  <= head_d;
      rd_valid_q <= (fill_d != '0);
      ovf_q      <= ovf_d;
    end
  end

  assign CS_b         = cs_b_q;
  assign sclk         = sclk_q;
  assign sample_pulse = pulse_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign fill_count   = fill_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_mic_spi_capture_fifo.sv
// Directed bench for mic_spi_capture_fifo: ADC model on MISO, frame timing, FIFO fill/overflow, reset and enable cases.
module tb_mic_spi_capture_fifo;

  localparam int unsigned SAMPLE_DIV = 500;
  localparam int unsigned SCLK_DIV   = 2;
  localparam int unsigned DEPTH      = 16;

`ifdef MIC_FIFO_DROP_OLDEST_EN
  localparam logic [15:0] H17  = 16'hA5C4;
  localparam logic [15:0] H18  = 16'hA5C5;
  localparam logic [15:0] H19  = 16'hA5C6;
  localparam logic [15:0] HPOP = 16'hA5C7;
`else
  localparam logic [15:0] H17  = 16'hA5C3;
  localparam logic [15:0] H18  = 16'hA5C3;
  localparam logic [15:0] H19  = 16'hA5C4;
  localparam logic [15:0] HPOP = 16'hA5C5;
`endif

  logic        fixed_clock = 1'b0;
  logic        PRESETn;
  logic        enable;
  logic        MISO = 1'b0;
  logic        CS_b;
  logic        sclk;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fill_count;
  logic        sample_pulse;
  logic        overflow;
  logic        overflow_clr;

  int errors = 0;
  int checks = 0;

  mic_spi_capture_fifo #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .SCLK_DIV  (SCLK_DIV),
    .DEPTH     (DEPTH)
  ) dut (
    .fixed_clock (fixed_clock),
    .PRESETn     (PRESETn),
    .enable      (enable),
    .MISO        (MISO),
    .CS_b        (CS_b),
    .sclk        (sclk),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fill_count  (fill_count),
    .sample_pulse(sample_pulse),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 fixed_clock = ~fixed_clock;

  // ADC model and pin monitor: word for frame k is A5C3+k, next bit presented after each sclk rise
  int          cyc = 0, frame_idx = 0, bitn = 0, rise_cnt = 0, last_rise = 0;
  int          cs_falls = 0, pulses = 0, idle_viol = 0, period_viol = 0;
  logic [15:0] cur_word = 16'h0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;

  always @(negedge fixed_clock) begin
    cyc++;
    if (sample_pulse) pulses++;
    if (CS_b && !sclk) idle_viol++;
    if (prev_cs && !CS_b) begin
      cur_word = 16'hA5C3 + frame_idx[15:0];
      frame_idx++;
      cs_falls++;
      rise_cnt = 0;
      bitn = 15;
      MISO = cur_word[15];
    end else if (!CS_b && !prev_sclk && sclk) begin
      if (rise_cnt > 0 && (cyc - last_rise) != int'(2 * SCLK_DIV)) period_viol++;
      last_rise = cyc;
      rise_cnt++;
      bitn--;
      MISO = (bitn >= 0) ? cur_word[bitn] : 1'b0;
    end
    prev_cs   = CS_b;
    prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cs_fall(output int n);
    n = 0;
    while (CS_b === 1'b1 && n < 1000) begin
      @(negedge fixed_clock);
      n++;
    end
    if (CS_b !== 1'b0) chk("cs_fall_timeout", 32'(CS_b), 32'd0);
  endtask

  // Returns on the negedge inside the PUSH cycle
  task automatic wait_pulse(input int lim);
    int n;
    n = 0;
    while (sample_pulse !== 1'b1 && n < lim) begin
      @(negedge fixed_clock);
      n++;
    end
    if (sample_pulse !== 1'b1) chk("pulse_timeout", 32'(sample_pulse), 32'd1);
  endtask

  initial begin
    int n, m, falls0;
    logic [15:0] exp_word;
    PRESETn = 1'b0;
    enable = 1'b1;
    rd_en = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) @(negedge fixed_clock);
    chk("rst_cs_b", 32'(CS_b), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_pulse", 32'(sample_pulse), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // First frame: timing and captured word
    PRESETn = 1'b1;
    wait_cs_fall(n);
    chk("first_cs_fall", 32'(n), 32'(SAMPLE_DIV));
    m = 0;
    while (sample_pulse !== 1'b1 && m < 200) begin
      @(negedge fixed_clock);
      m++;
    end
    chk("cs_to_pulse", 32'(m), 32'(34 * SCLK_DIV));
    @(negedge fixed_clock);
    chk("f0_rd_data", 32'(rd_data), 32'hA5C3);
    chk("f0_rd_valid", 32'(rd_valid), 32'd1);
    chk("f0_fill", 32'(fill_count), 32'd1);
    chk("f0_pulses", 32'(pulses), 32'd1);
    chk("f0_sclk_rises", 32'(rise_cnt), 32'd16);
    chk("f0_sample_pulse_low", 32'(sample_pulse), 32'd0);

    // Fill to DEPTH without popping
    repeat (15) begin
      wait_pulse(600);
      @(negedge fixed_clock);
    end
    chk("full_fill", 32'(fill_count), 32'd16);
    chk("full_ovf", 32'(overflow), 32'd0);
    chk("full_head", 32'(rd_data), 32'hA5C3);

    // 17th frame on full FIFO
    wait_pulse(600);
    @(negedge fixed_clock);
    chk("f17_ovf", 32'(overflow), 32'd1);
    chk("f17_fill", 32'(fill_count), 32'd16);
    chk("f17_head", 32'(rd_data), 32'(H17));

    // 18th frame: clear asserted in the same cycle as a new overflow
    wait_pulse(600);
    overflow_clr = 1'b1;
    @(negedge fixed_clock);
    overflow_clr = 1'b0;
    chk("f18_set_wins", 32'(overflow), 32'd1);
    chk("f18_fill", 32'(fill_count), 32'd16);
    chk("f18_head", 32'(rd_data), 32'(H18));
    overflow_clr = 1'b1;
    @(negedge fixed_clock);
    overflow_clr = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // 19th frame: pop held on the PUSH cycle of a full FIFO
    wait_pulse(600);
    rd_en = 1'b1;
    @(negedge fixed_clock);
    rd_en = 1'b0;
    chk("f19_fill", 32'(fill_count), 32'd16);
    chk("f19_ovf", 32'(overflow), 32'd0);
    chk("f19_head", 32'(rd_data), 32'(H19));
    rd_en = 1'b1;
    @(negedge fixed_clock);
    rd_en = 1'b0;
    chk("pop_fill", 32'(fill_count), 32'd15);
    chk("pop_head", 32'(rd_data), 32'(HPOP));

    // Reset during SHIFT around bit 7 while sclk is low
    wait_cs_fall(n);
    m = 0;
    while (!(rise_cnt >= 7 && sclk === 1'b0) && m < 200) begin
      @(negedge fixed_clock);
      m++;
    end
    chk("midshift_sclk_low", 32'(sclk), 32'd0);
    PRESETn = 1'b0;
    #1;
    chk("midrst_cs_b", 32'(CS_b), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd1);
    chk("midrst_fill", 32'(fill_count), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    repeat (2) @(negedge fixed_clock);
    PRESETn = 1'b1;
    wait_cs_fall(n);
    chk("rerst_cs_fall", 32'(n), 32'(SAMPLE_DIV));

    // Drop enable mid-frame: frame completes, then capture stops
    repeat (10) @(negedge fixed_clock);
    enable = 1'b0;
    wait_pulse(200);
    @(negedge fixed_clock);
    exp_word = 16'hA5C3 + 16'(frame_idx - 1);
    chk("dis_fill", 32'(fill_count), 32'd1);
    chk("dis_rd_data", 32'(rd_data), 32'(exp_word));
    falls0 = cs_falls;
    repeat (1200) @(negedge fixed_clock);
    chk("dis_no_frames", 32'(cs_falls - falls0), 32'd0);
    chk("dis_cs_idle", 32'(CS_b), 32'd1);
    rd_en = 1'b1;
    @(negedge fixed_clock);
    chk("drain_fill", 32'(fill_count), 32'd0);
    chk("drain_valid", 32'(rd_valid), 32'd0);
    repeat (2) @(negedge fixed_clock);
    rd_en = 1'b0;
    chk("empty_pop_fill", 32'(fill_count), 32'd0);
    chk("empty_pop_valid", 32'(rd_valid), 32'd0);

    chk("sclk_high_when_idle", 32'(idle_viol), 32'd0);
    chk("sclk_period", 32'(period_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
